// File: rtl/periph_bus_master.sv
// periph_bus_master: buffers peripheral read/write commands in a small FIFO and
// plays them onto a registered single-cycle peripheral bus, one at a time,
// returning exactly one in-order response per accepted command.
module periph_bus_master #(
    parameter int unsigned FIFO_DEPTH = 4,   // power of two, >= 2
    parameter int unsigned MAX_ADDR   = 24   // highest valid word-aligned address
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [4:0]  A,
    output logic [31:0] WD,
    output logic        WE,
    input  logic [31:0] RD,
    output logic        busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic        write;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // A command may touch the bus only if it is word aligned and in range.
    function automatic logic addr_ok(input logic [4:0] addr);
        return (addr[1:0] == 2'b00) && (32'(addr) <= MAX_ADDR);
    endfunction

    cmd_t           fifo_mem [FIFO_DEPTH];
    cmd_t           cmd_in;
    cmd_t           head;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;

    state_t         state_q, state_d;
    logic [4:0]     a_q, a_d;
    logic [31:0]    wd_q, wd_d;
    logic           we_q, we_d;
    logic           cur_write_q, cur_write_d;
    logic           cur_err_q, cur_err_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic           rsp_write_q, rsp_write_d;
    logic           rsp_err_q, rsp_err_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full && !rst;
    assign cmd_in     = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_err    = rsp_err_q;
    assign A          = a_q;
    assign WD         = wd_q;
    assign WE         = we_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;

    // Command storage: written on accept, read at the head pointer.
    // NOTE: the payload array has no reset; the pointers alone define which
    // entries are live, so flushing them is enough and keeps this plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_in;
        end
    end

    // Sequencer: pop the head when the bus is free, one issue cycle, then
    // hold the response until the consumer takes it.
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next-state: bus drive for the coming issue cycle, response capture.
    always_comb begin
        wr_ptr_d    = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        a_d         = '0;
        wd_d        = '0;
        we_d        = 1'b0;
        cur_write_d = cur_write_q;
        cur_err_d   = cur_err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;

        if (pop) begin
            a_d         = head.addr;
            wd_d        = head.wdata;
            we_d        = head.write && addr_ok(head.addr);
            cur_write_d = head.write;
            cur_err_d   = !addr_ok(head.addr);
        end

        // Read data is sampled at the edge that closes the issue cycle.
        if (state_q == ISSUE) begin
            rsp_write_d = cur_write_q;
            rsp_err_d   = cur_err_q;
            rsp_rdata_d = (!cur_write_q && !cur_err_q) ? RD : 32'h0;
        end
    end

    // State and output registers with synchronous reset.
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; the combinational blocks above use blocking ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            a_q         <= '0;
            wd_q        <= '0;
            we_q        <= 1'b0;
            cur_write_q <= 1'b0;
            cur_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            we_q        <= we_d;
            cur_write_q <= cur_write_d;
            cur_err_q   <= cur_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_periph_bus_master.sv
// Testbench for periph_bus_master: scenario tasks with inline checks plus a
// response scoreboard filled on every accepted command.
module tb_periph_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_err;
    logic [4:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic        busy;

    typedef struct {
        logic        w;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   we_count = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b0;

    periph_bus_master #(.FIFO_DEPTH(4), .MAX_ADDR(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .A         (A),
        .WD        (WD),
        .WE        (WE),
        .RD        (RD),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral responder model: distinct data per address.
    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd20) return 32'h0000_1234;
        return {27'h0654321, a};
    endfunction

    assign RD = rd_model(A);

    function automatic exp_t exp_model(input logic w, input logic [4:0] a);
        exp_t e;
        logic ok;
        ok      = ((int'(a) % 4) == 0) && (int'(a) <= 24);
        e.w     = w;
        e.err   = !ok;
        e.rdata = (!w && ok) ? rd_model(a) : 32'h0;
        return e;
    endfunction

    // Scoreboard: handshakes are judged mid-cycle, before the edge that takes them.
    always @(negedge clk) begin
        exp_t e;
        if (WE) we_count++;
        if (rst) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected: got w=%0b err=%0b rdata=%h, required no response",
                             rsp_write, rsp_err, rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_write, rsp_err, rsp_rdata} !== {e.w, e.err, e.rdata})
                        $display("FAIL rsp_data: got w=%0b err=%0b rdata=%h, required w=%0b err=%0b rdata=%h",
                                 rsp_write, rsp_err, rsp_rdata, e.w, e.err, e.rdata);
                    else
                        n_pass++;
                end
            end
            if (cmd_valid && cmd_ready) sb.push_back(exp_model(cmd_write, cmd_addr));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_cmd(input logic w, input logic [4:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                next_cycle();
                cmd_valid = 1'b0;
                return;
            end
            next_cycle();
        end
        n_checks++;
        $display("FAIL send_timeout: cmd_ready stayed %0b for 100 cycles, required 1", cmd_ready);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                next_cycle();
                return;
            end
            next_cycle();
        end
        n_checks++;
        $display("FAIL idle_timeout: busy=%0b after 200 cycles, required 0", busy);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'd4;
        cmd_wdata = 32'hDEAD_BEEF;
        next_cycle();
        next_cycle();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_write, rsp_err, WE, busy} !== 5'b0)
            $display("FAIL reset_flags: got valid/write/err/WE/busy=%b, required 00000",
                     {rsp_valid, rsp_write, rsp_err, WE, busy});
        else n_pass++;
        n_checks++;
        if ({A, WD, rsp_rdata} !== 69'b0)
            $display("FAIL reset_data: got A=%0d WD=%h rdata=%h, required all 0", A, WD, rsp_rdata);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1)
            $display("FAIL reset_ready: got cmd_ready=%0b, required 1", cmd_ready);
        else n_pass++;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({busy, rsp_valid, WE} !== 3'b0)
            $display("FAIL reset_no_accept: got busy/rsp_valid/WE=%b, required 000", {busy, rsp_valid, WE});
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_single_write();
        int w0;
        w0 = we_count;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'd4;
        cmd_wdata = 32'h0000_A5A5;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL wr_ready: got %0b, required 1", cmd_ready);
        else n_pass++;
        next_cycle();
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({WE, A} !== 6'b0) $display("FAIL wr_cycle1_bus: got WE=%0b A=%0d, required 0/0", WE, A);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({A, WD, WE} !== {5'd4, 32'h0000_A5A5, 1'b1})
            $display("FAIL wr_issue: got A=%0d WD=%h WE=%0b, required A=4 WD=0000a5a5 WE=1", A, WD, WE);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, WE} !== {3'b110, 32'h0, 1'b0})
            $display("FAIL wr_resp: got valid=%0b write=%0b err=%0b rdata=%h WE=%0b, required 1 1 0 0 0",
                     rsp_valid, rsp_write, rsp_err, rsp_rdata, WE);
        else n_pass++;
        wait_idle();
        n_checks++;
        if (we_count - w0 != 1) $display("FAIL wr_we_cycles: got %0d, required 1", we_count - w0);
        else n_pass++;
    endtask

    task automatic test_single_read();
        int w0;
        w0 = we_count;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 5'd20;
        cmd_wdata = 32'h0;
        next_cycle();
        cmd_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({A, WE} !== {5'd20, 1'b0}) $display("FAIL rd_issue: got A=%0d WE=%0b, required A=20 WE=0", A, WE);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {3'b100, 32'h0000_1234})
            $display("FAIL rd_resp: got valid=%0b write=%0b err=%0b rdata=%h, required 1 0 0 00001234",
                     rsp_valid, rsp_write, rsp_err, rsp_rdata);
        else n_pass++;
        wait_idle();
        n_checks++;
        if (we_count != w0) $display("FAIL rd_we: got %0d WE cycles, required 0", we_count - w0);
        else n_pass++;
    endtask

    task automatic test_addr_errors();
        int w0;
        w0 = we_count;
        send_cmd(1'b1, 5'd6,  32'h1111_1111);
        send_cmd(1'b1, 5'd28, 32'h2222_2222);
        send_cmd(1'b0, 5'd24, 32'h0);
        send_cmd(1'b0, 5'd26, 32'h0);
        send_cmd(1'b1, 5'd24, 32'h3333_3333);
        wait_idle();
        n_checks++;
        if (we_count - w0 != 1) $display("FAIL err_we: got %0d WE cycles, required 1", we_count - w0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic       tw [6];
        logic [4:0] ta [6];
        int         t[$];
        exp_t       e0;
        tw = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ta = '{5'd8, 5'd0, 5'd20, 5'd12, 5'd16, 5'd4};
        e0 = exp_model(1'b0, 5'd8);
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_write = tw[i];
            cmd_addr  = ta[i];
            cmd_wdata = 32'h100 + 32'(i);
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== (i < 5)) $display("FAIL bp_ready_%0d: got %0b, required %0b", i, cmd_ready, i < 5);
            else n_pass++;
            next_cycle();
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== 1'b0) $display("FAIL bp_full_%0d: got cmd_ready=%0b, required 0", j, cmd_ready);
            else n_pass++;
            next_cycle();
        end
        cmd_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {1'b1, e0.w, e0.err, e0.rdata})
                $display("FAIL bp_hold_%0d: got valid=%0b rdata=%h, required 1 %h", j, rsp_valid, rsp_rdata, e0.rdata);
            else n_pass++;
            next_cycle();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) t.push_back(cyc);
            next_cycle();
        end
        n_checks++;
        if (t.size() != 5) $display("FAIL bp_count: got %0d responses, required 5", t.size());
        else n_pass++;
        for (int i = 1; i < t.size(); i++) begin
            n_checks++;
            if (t[i] - t[i-1] != 2) $display("FAIL bp_spacing_%0d: got %0d cycles, required 2", i, t[i] - t[i-1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_cmd(1'b0, 5'(4 * i), 32'h0);
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy} !== 2'b11) $display("FAIL mid_resp: got valid/busy=%b, required 11", {rsp_valid, busy});
        else n_pass++;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001)
            $display("FAIL mid_after_rst: got valid/busy/ready=%b, required 001", {rsp_valid, busy, cmd_ready});
        else n_pass++;
        next_cycle();
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
            next_cycle();
        end
        n_checks++;
        if (seen != 0) $display("FAIL mid_quiet: got %0d active cycles, required 0", seen);
        else n_pass++;
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            send_cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
        rand_ready = 1'b0;
        rsp_ready  = 1'b1;
        wait_idle();
        n_checks++;
        if (sb.size() != 0) $display("FAIL rand_drain: got %0d outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_addr_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
